// File: rtl/reconf_dsp_fir_cfg_loader.sv
// Stages host microcode words and replays them into the FIR config port after a config reset.
// Optional RECONF_DSP_FIR_CFG_CHECKSUM_EN adds an XOR checksum of the streamed words.
module reconf_dsp_fir_cfg_loader #(
  parameter int unsigned CFG_WIDTH  = 32,
  parameter int unsigned DEPTH_BITS = 9,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [CFG_WIDTH-1:0]  wr_data,
  output logic                  wr_ready,
  input  logic                  commit,
  input  logic                  abort,
  output logic                  cfg_rst,
  output logic                  cfg_valid,
  output logic [CFG_WIDTH-1:0]  cfg_data,
  output logic                  busy,
  output logic                  load_done,
`ifdef RECONF_DSP_FIR_CFG_CHECKSUM_EN
  output logic [CFG_WIDTH-1:0]  cfg_checksum,
`endif
  output logic [DEPTH_BITS:0]   staged_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam int unsigned CNT_W = DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [3:0]       RST_LAST = 4'(RST_CYCLES - 1);

  // PREFETCH is kept for encoding stability; the first read overlaps the last RST cycle.
  typedef enum logic [2:0] {IDLE, RST, PREFETCH, STREAM, DONE} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       tx_q, tx_d;
  logic [3:0]             rstc_q, rstc_d;
  logic                   wr_en_c, rd_en_c;
  logic [DEPTH_BITS-1:0]  rd_addr_c;
  logic [CFG_WIDTH-1:0]   mem [DEPTH];

  logic                   wr_ready_q, cfg_rst_q, cfg_valid_q, busy_q, load_done_q;
  logic [CFG_WIDTH-1:0]   cfg_data_q;

  // Next-state, counters and RAM strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rstc_d    = rstc_q;
    wr_en_c   = 1'b0;
    rd_en_c   = 1'b0;
    rd_addr_c = '0;
    case (state_q)
      IDLE: begin
        if (abort) begin
          cnt_d = '0;
        end else begin
          if (wr_valid && (cnt_q < FULL)) begin
            wr_en_c = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
          if (commit) begin
            state_d = RST;
            rstc_d  = '0;
          end
        end
      end
      RST: begin
        if (abort) begin
          state_d = DONE;
        end else if (rstc_q == RST_LAST) begin
          tx_d    = '0;
          rd_en_c = (cnt_q != '0);
          state_d = (cnt_q != '0) ? STREAM : DONE;
        end else begin
          rstc_d = rstc_q + 4'(1);
        end
      end
      STREAM: begin
        if (abort || (tx_q == cnt_q - CNT_W'(1))) begin
          state_d = DONE;
        end else begin
          tx_d      = tx_q + CNT_W'(1);
          rd_en_c   = 1'b1;
          rd_addr_c = tx_q[DEPTH_BITS-1:0] + DEPTH_BITS'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_q        <= '0;
      rstc_q      <= '0;
      wr_ready_q  <= 1'b1;
      cfg_rst_q   <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_data_q  <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rstc_q      <= rstc_d;
      wr_ready_q  <= (state_d == IDLE) && (cnt_d < FULL);
      cfg_rst_q   <= (state_d == RST);
      cfg_valid_q <= (state_d == STREAM);
      busy_q      <= (state_d != IDLE);
      load_done_q <= (state_d == DONE);
      if (rd_en_c) cfg_data_q <= mem[rd_addr_c];
    end
  end

  // Staging RAM: the low bits of the staged count act as the write pointer
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[cnt_q[DEPTH_BITS-1:0]] <= wr_data;
  end

`ifdef RECONF_DSP_FIR_CFG_CHECKSUM_EN
  logic [CFG_WIDTH-1:0] cks_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cks_q <= '0;
    end else if ((state_q == IDLE) && (state_d == RST)) begin
      cks_q <= '0;
    end else if (cfg_valid_q) begin
      cks_q <= cks_q ^ cfg_data_q;
    end
  end

  assign cfg_checksum = cks_q;
`endif

  assign wr_ready   = wr_ready_q;
  assign cfg_rst    = cfg_rst_q;
  assign cfg_valid  = cfg_valid_q;
  assign cfg_data   = cfg_data_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign staged_cnt = cnt_q;

endmodule

// File: tb/tb_reconf_dsp_fir_cfg_loader.sv
// Directed bench for reconf_dsp_fir_cfg_loader: staging, streaming, abort, async reset, optional checksum.
module tb_reconf_dsp_fir_cfg_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        commit;
  logic        abort;
  logic        cfg_rst;
  logic        cfg_valid;
  logic [31:0] cfg_data;
  logic        busy;
  logic        load_done;
  logic [9:0]  staged_cnt;
`ifdef RECONF_DSP_FIR_CFG_CHECKSUM_EN
  logic [31:0] cfg_checksum;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model [512];
  int          model_n = 0;

  reconf_dsp_fir_cfg_loader #(.CFG_WIDTH(32), .DEPTH_BITS(9), .RST_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .commit     (commit),
    .abort      (abort),
    .cfg_rst    (cfg_rst),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .busy       (busy),
    .load_done  (load_done),
`ifdef RECONF_DSP_FIR_CFG_CHECKSUM_EN
    .cfg_checksum (cfg_checksum),
`endif
    .staged_cnt (staged_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] d);
    chk("wr_ready_before_write", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    model[model_n] = d;
    model_n++;
  endtask

  // Commit and check the whole load: 2 reset cycles, n gap-free words, done pulse, empty buffer
  task automatic load_check(input int n);
    logic [31:0] x;
    x = 32'h0;
    chk("staged_before_commit", 32'(staged_cnt), 32'(n));
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int r = 0; r < 2; r++) begin
      chk("rst_phase_cfg_rst", 32'(cfg_rst), 32'd1);
      chk("rst_phase_cfg_valid", 32'(cfg_valid), 32'd0);
      chk("rst_phase_busy", 32'(busy), 32'd1);
      tick();
    end
    for (int k = 0; k < n; k++) begin
      chk("stream_cfg_valid", 32'(cfg_valid), 32'd1);
      chk("stream_cfg_rst", 32'(cfg_rst), 32'd0);
      chk("stream_cfg_data", cfg_data, model[k]);
      x = x ^ model[k];
      tick();
    end
    chk("done_load_done", 32'(load_done), 32'd1);
    chk("done_cfg_valid", 32'(cfg_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
`ifdef RECONF_DSP_FIR_CFG_CHECKSUM_EN
    chk("done_checksum", cfg_checksum, x);
`endif
    tick();
    chk("after_load_done", 32'(load_done), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_staged_cnt", 32'(staged_cnt), 32'd0);
    chk("after_wr_ready", 32'(wr_ready), 32'd1);
    model_n = 0;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 32'h0; commit = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("reset_wr_ready", 32'(wr_ready), 32'd1);
    chk("reset_cfg_rst", 32'(cfg_rst), 32'd0);
    chk("reset_cfg_valid", 32'(cfg_valid), 32'd0);
    chk("reset_cfg_data", cfg_data, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_load_done", 32'(load_done), 32'd0);
    chk("reset_staged_cnt", 32'(staged_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Three-word load
    write_word(32'h11111111);
    write_word(32'h22222222);
    write_word(32'h33333333);
    load_check(3);

    // Fill to capacity, then a held 513th word
    for (int i = 0; i < 512; i++) begin
      chk("fill_wr_ready", 32'(wr_ready), 32'd1);
      wr_valid = 1'b1;
      wr_data  = 32'h5A000000 ^ (32'(i) * 32'h00010003);
      model[i] = wr_data;
      tick();
    end
    model_n = 512;
    wr_data = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      chk("full_wr_ready", 32'(wr_ready), 32'd0);
      chk("full_staged_cnt", 32'(staged_cnt), 32'd512);
      tick();
    end
    wr_valid = 1'b0;
    load_check(512);

    // Reset-only load
    load_check(0);

    // Abort in IDLE clears the buffer without a done pulse
    write_word(32'hCAFE0001);
    write_word(32'hCAFE0002);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_staged", 32'(staged_cnt), 32'd0);
    chk("idle_abort_load_done", 32'(load_done), 32'd0);
    chk("idle_abort_wr_ready", 32'(wr_ready), 32'd1);
    model_n = 0;
    tick();
    chk("idle_abort_no_pulse", 32'(load_done), 32'd0);

    // Ten words: commit at word 4 ignored, abort at word 6
    for (int i = 0; i < 10; i++) write_word(32'hA0000000 + 32'(i));
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    chk("abort_run_rst", 32'(cfg_rst), 32'd1);
    tick();
    for (int k = 0; k <= 6; k++) begin
      chk("abort_run_valid", 32'(cfg_valid), 32'd1);
      chk("abort_run_data", cfg_data, model[k]);
      if (k == 4) commit = 1'b1;
      if (k == 6) abort = 1'b1;
      tick();
      commit = 1'b0;
      abort  = 1'b0;
    end
    chk("abort_cfg_valid", 32'(cfg_valid), 32'd0);
    chk("abort_load_done", 32'(load_done), 32'd1);
    chk("abort_cfg_data_hold", cfg_data, model[6]);
    chk("abort_cfg_rst", 32'(cfg_rst), 32'd0);
    tick();
    chk("abort_after_staged", 32'(staged_cnt), 32'd0);
    chk("abort_after_busy", 32'(busy), 32'd0);
    chk("abort_after_load_done", 32'(load_done), 32'd0);
    model_n = 0;

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) write_word(32'h77000000 + 32'(i));
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick(); tick(); tick();
    chk("pre_areset_valid", 32'(cfg_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("areset_cfg_valid", 32'(cfg_valid), 32'd0);
    chk("areset_cfg_rst", 32'(cfg_rst), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_staged", 32'(staged_cnt), 32'd0);
    chk("areset_wr_ready", 32'(wr_ready), 32'd1);
    chk("areset_cfg_data", cfg_data, 32'h0);
    #1;
    rst_n = 1'b1;
    model_n = 0;
    tick();

    // Recovery load after reset
    write_word(32'hA5A5A5A5);
    write_word(32'h0F0F0F0F);
`ifdef RECONF_DSP_FIR_CFG_CHECKSUM_EN
    chk("checksum_expected_const", 32'hA5A5A5A5 ^ 32'h0F0F0F0F, 32'hAAAAAAAA);
`endif
    load_check(2);
`ifdef RECONF_DSP_FIR_CFG_CHECKSUM_EN
    chk("checksum_stable", cfg_checksum, 32'hAAAAAAAA);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
